// File: rtl/lagarto_dcache_req_tracker_if.sv
// rtl/lagarto_dcache_req_tracker_if.sv - CPU-side and dcache-side signal bundle of the request tracker
interface lagarto_dcache_req_tracker_if #(
  parameter int  DEPTH  = 4,
  parameter int  ADDR_W = 64,
  parameter int  DATA_W = 64,
  localparam int ID_W   = $clog2(DEPTH)
);
  // CPU request channel
  logic                req_valid_i;
  logic                req_ready_o;
  logic                req_is_store_i;
  logic [ADDR_W-1:0]   req_addr_i;
  logic [63:0]         req_wdata_i;
  logic [1:0]          req_size_i;
  logic                kill_i;

  // dcache request channel
  logic                mem_req_valid_o;
  logic                mem_req_ready_i;
  logic [ID_W-1:0]     mem_req_id_o;
  logic [ADDR_W-1:0]   mem_req_addr_o;
  logic                mem_req_we_o;
  logic [DATA_W-1:0]   mem_req_wdata_o;
  logic [DATA_W/8-1:0] mem_req_be_o;

  // dcache response channel
  logic                mem_resp_valid_i;
  logic [ID_W-1:0]     mem_resp_id_i;
  logic [DATA_W-1:0]   mem_resp_data_i;

  // CPU retire channel
  logic                resp_valid_o;
  logic                resp_is_store_o;
  logic [63:0]         resp_data_o;
  logic [ADDR_W-1:0]   resp_addr_o;
  logic                resp_xcpt_ma_o;
  logic [ID_W:0]       occupancy_o;

  // Tracker side
  modport slave (
    input  req_valid_i, req_is_store_i, req_addr_i, req_wdata_i, req_size_i, kill_i,
    input  mem_req_ready_i, mem_resp_valid_i, mem_resp_id_i, mem_resp_data_i,
    output req_ready_o, mem_req_valid_o, mem_req_id_o, mem_req_addr_o, mem_req_we_o,
    output mem_req_wdata_o, mem_req_be_o,
    output resp_valid_o, resp_is_store_o, resp_data_o, resp_addr_o, resp_xcpt_ma_o, occupancy_o
  );

  // CPU pipeline plus dcache side
  modport master (
    output req_valid_i, req_is_store_i, req_addr_i, req_wdata_i, req_size_i, kill_i,
    output mem_req_ready_i, mem_resp_valid_i, mem_resp_id_i, mem_resp_data_i,
    input  req_ready_o, mem_req_valid_o, mem_req_id_o, mem_req_addr_o, mem_req_we_o,
    input  mem_req_wdata_o, mem_req_be_o,
    input  resp_valid_o, resp_is_store_o, resp_data_o, resp_addr_o, resp_xcpt_ma_o, occupancy_o
  );
endinterface

// File: rtl/lagarto_dcache_req_tracker.sv
// rtl/lagarto_dcache_req_tracker.sv - in-order issue, out-of-order completion, in-order retire dcache request table
module lagarto_dcache_req_tracker #(
  parameter int  DEPTH  = 4,
  parameter int  ADDR_W = 64,
  parameter int  DATA_W = 64,
  localparam int ID_W   = $clog2(DEPTH)
) (
  input logic                         clk_i,
  input logic                         rstn_i,
  lagarto_dcache_req_tracker_if.slave bus
);

  localparam int PTR_W = ID_W + 1;
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  typedef enum logic [1:0] {FREE, PEND, ISSUED, DONE} ent_state_e;

  ent_state_e        state_q [DEPTH];
  ent_state_e        state_d [DEPTH];
  logic [DEPTH-1:0]  killed_q, killed_d;
  logic [DEPTH-1:0]  is_store_q, is_store_d;
  logic [DEPTH-1:0]  xcpt_q, xcpt_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [1:0]        size_q [DEPTH];
  logic [1:0]        size_d [DEPTH];
  logic [63:0]       wdata_q [DEPTH];
  logic [63:0]       wdata_d [DEPTH];
  logic [DATA_W-1:0] rdata_q [DEPTH];
  logic [DATA_W-1:0] rdata_d [DEPTH];
  logic [PTR_W-1:0]  alloc_q, alloc_d;
  logic [PTR_W-1:0]  issue_q, issue_d;
  logic [PTR_W-1:0]  retire_q, retire_d;

  logic [ID_W-1:0]   alloc_idx, issue_idx, retire_idx;
  logic [PTR_W-1:0]  occupancy;
  logic [OFF_W-1:0]  issue_off, retire_off;
  logic              alloc_fire, misaligned, req_valid, issue_fire, issue_skip;
  logic              resp_hit, retire_fire, retire_visible;

  // Value mask covering 2^size bytes
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Byte-enable pattern for 2^size bytes before lane shifting
  function automatic logic [7:0] byte_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // An access is misaligned when its address is not a multiple of its size
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return addr_lo[0];
      2'd2:    return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

  assign alloc_idx  = alloc_q[ID_W-1:0];
  assign issue_idx  = issue_q[ID_W-1:0];
  assign retire_idx = retire_q[ID_W-1:0];
  assign occupancy  = alloc_q - retire_q;
  assign issue_off  = addr_q[issue_idx][OFF_W-1:0];
  assign retire_off = addr_q[retire_idx][OFF_W-1:0];

  // Admission uses the registered occupancy; a retire this cycle frees its slot next cycle
  assign bus.req_ready_o = rstn_i && (occupancy < DEPTH_P) && !bus.kill_i;
  assign alloc_fire      = bus.req_valid_i && bus.req_ready_o;
  assign misaligned      = is_misaligned(bus.req_addr_i[2:0], bus.req_size_i);

  // Issue is decided from registered state; kill gates it combinationally
  assign req_valid  = (state_q[issue_idx] == PEND) && !bus.kill_i;
  assign issue_fire = req_valid && bus.mem_req_ready_i;
  // Misaligned entries are DONE at the issue pointer and are stepped over without a dcache access
  assign issue_skip = !bus.kill_i && (issue_q != alloc_q) && (state_q[issue_idx] == DONE);
  assign resp_hit   = bus.mem_resp_valid_i && (state_q[bus.mem_resp_id_i] == ISSUED);

  assign retire_fire    = (state_q[retire_idx] == DONE);
  assign retire_visible = retire_fire && !killed_q[retire_idx] && !bus.kill_i;

  assign bus.mem_req_valid_o = req_valid;
  assign bus.mem_req_id_o    = req_valid ? issue_idx : '0;
  assign bus.mem_req_addr_o  = req_valid ? addr_q[issue_idx] : '0;
  assign bus.mem_req_we_o    = req_valid && is_store_q[issue_idx];
  assign bus.mem_req_wdata_o = req_valid ? (DATA_W'(wdata_q[issue_idx]) << {issue_off, 3'b000}) : '0;
  assign bus.mem_req_be_o    = req_valid ? (BE_W'(byte_mask(size_q[issue_idx])) << issue_off) : '0;

  assign bus.resp_valid_o    = retire_visible;
  assign bus.resp_is_store_o = retire_visible && is_store_q[retire_idx];
  assign bus.resp_addr_o     = retire_visible ? addr_q[retire_idx] : '0;
  assign bus.resp_xcpt_ma_o  = retire_visible && xcpt_q[retire_idx];
  assign bus.resp_data_o     = (retire_visible && !is_store_q[retire_idx] && !xcpt_q[retire_idx]) ?
                               (64'(rdata_q[retire_idx] >> {retire_off, 3'b000}) & size_mask(size_q[retire_idx])) :
                               '0;
  assign bus.occupancy_o     = occupancy;

  // Next-state for the table and pointers: allocate, issue, respond, retire, then kill overrides
  always_comb begin
    state_d    = state_q;
    killed_d   = killed_q;
    is_store_d = is_store_q;
    xcpt_d     = xcpt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    alloc_d    = alloc_q;
    issue_d    = issue_q;
    retire_d   = retire_q;

    if (alloc_fire) begin
      state_d[alloc_idx]    = misaligned ? DONE : PEND;
      killed_d[alloc_idx]   = 1'b0;
      is_store_d[alloc_idx] = bus.req_is_store_i;
      xcpt_d[alloc_idx]     = misaligned;
      addr_d[alloc_idx]     = bus.req_addr_i;
      size_d[alloc_idx]     = bus.req_size_i;
      wdata_d[alloc_idx]    = bus.req_wdata_i & size_mask(bus.req_size_i);
      rdata_d[alloc_idx]    = '0;
      alloc_d               = alloc_q + PTR_W'(1);
    end

    if (issue_fire) begin
      state_d[issue_idx] = is_store_q[issue_idx] ? DONE : ISSUED;
      issue_d            = issue_q + PTR_W'(1);
    end else if (issue_skip) begin
      issue_d = issue_q + PTR_W'(1);
    end

    if (resp_hit) begin
      state_d[bus.mem_resp_id_i] = DONE;
      rdata_d[bus.mem_resp_id_i] = bus.mem_resp_data_i;
    end

    if (retire_fire) begin
      state_d[retire_idx]  = FREE;
      killed_d[retire_idx] = 1'b0;
      retire_d             = retire_q + PTR_W'(1);
    end

    // Issued loads keep waiting for their response; unissued ones are finished in place
    if (bus.kill_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (state_d[i] != FREE) begin
          killed_d[i] = 1'b1;
          if (state_d[i] == PEND) state_d[i] = DONE;
        end
      end
      issue_d = alloc_q;
    end
  end

  // Table and pointer registers with synchronous clear
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= FREE;
        addr_q[i]  <= '0;
        size_q[i]  <= '0;
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
      end
      killed_q   <= '0;
      is_store_q <= '0;
      xcpt_q     <= '0;
      alloc_q    <= '0;
      issue_q    <= '0;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      killed_q   <= killed_d;
      is_store_q <= is_store_d;
      xcpt_q     <= xcpt_d;
      alloc_q    <= alloc_d;
      issue_q    <= issue_d;
      retire_q   <= retire_d;
    end
  end

  // A load response must name an entry that is waiting for one
  resp_targets_issued_a : assert property (@(posedge clk_i) disable iff (!rstn_i)
    bus.mem_resp_valid_i |-> (state_q[bus.mem_resp_id_i] == ISSUED));

endmodule

// File: tb/tb_lagarto_dcache_req_tracker.sv
// tb/tb_lagarto_dcache_req_tracker.sv - directed scoreboard bench for the dcache request tracker
module tb_lagarto_dcache_req_tracker;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic clk;
  logic rstn;

  lagarto_dcache_req_tracker_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

  lagarto_dcache_req_tracker #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (ifc)
  );

  typedef struct {
    logic        is_store;
    logic [63:0] addr;
    logic [63:0] data;
    logic        xcpt;
    logic        chk_data;
  } exp_t;

  exp_t sbq[$];
  int   n_asrt;
  int   n_fail;
  int   n_ret;
  int   n_alloc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    check("occupancy_bound", ifc.occupancy_o <= 3'd4, 1'b1);
    if (ifc.resp_valid_o === 1'b1) begin
      n_ret++;
      if (sbq.size() == 0) begin
        check("unexpected_resp", ifc.resp_valid_o, 1'b0);
      end else begin
        e = sbq.pop_front();
        check("resp_is_store", ifc.resp_is_store_o, e.is_store);
        check("resp_addr", ifc.resp_addr_o, e.addr);
        check("resp_xcpt_ma", ifc.resp_xcpt_ma_o, e.xcpt);
        if (e.chk_data) check("resp_data", ifc.resp_data_o, e.data);
      end
    end
  endtask

  task automatic neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    neg();
    pos();
  endtask

  task automatic do_req(input logic st, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [1:0] sz, input logic push, input logic [63:0] data,
                        input logic xcpt, output int tag);
    exp_t e;
    ifc.req_valid_i    = 1'b1;
    ifc.req_is_store_i = st;
    ifc.req_addr_i     = addr;
    ifc.req_wdata_i    = wd;
    ifc.req_size_i     = sz;
    neg();
    check("req_ready", ifc.req_ready_o, 1'b1);
    pos();
    ifc.req_valid_i = 1'b0;
    tag = n_alloc % DEPTH;
    n_alloc++;
    if (push) begin
      e = '{st, addr, data, xcpt, !st};
      sbq.push_back(e);
    end
  endtask

  task automatic grant(input int id, input logic [63:0] addr, input logic we,
                       input logic [7:0] be, output logic [63:0] wd);
    logic found;
    int   lat;
    found = 1'b0;
    lat   = 0;
    wd    = '0;
    ifc.mem_req_ready_i = 1'b1;
    for (int k = 0; k < 8 && !found; k++) begin
      neg();
      if (ifc.mem_req_valid_o === 1'b1) begin
        found = 1'b1;
        lat   = k;
        check("grant_id", ifc.mem_req_id_o, id);
        check("grant_addr", ifc.mem_req_addr_o, addr);
        check("grant_we", ifc.mem_req_we_o, we);
        check("grant_be", ifc.mem_req_be_o, be);
        wd = ifc.mem_req_wdata_o;
      end
      pos();
    end
    ifc.mem_req_ready_i = 1'b0;
    check("grant_seen", found, 1'b1);
    check("grant_latency", lat, 0);
  endtask

  task automatic respond(input int id, input logic [63:0] data);
    ifc.mem_resp_valid_i = 1'b1;
    ifc.mem_resp_id_i    = id[1:0];
    ifc.mem_resp_data_i  = data;
    tick();
    ifc.mem_resp_valid_i = 1'b0;
  endtask

  initial begin
    int          t, ta, tb_, te, r0;
    int          tg[4];
    int          order[4];
    logic [63:0] wd;
    logic [63:0] dat[4];
    exp_t        e;

    n_asrt = 0; n_fail = 0; n_ret = 0; n_alloc = 0;
    ifc.req_valid_i = 0; ifc.req_is_store_i = 0; ifc.req_addr_i = 0; ifc.req_wdata_i = 0;
    ifc.req_size_i = 0; ifc.kill_i = 0; ifc.mem_req_ready_i = 0;
    ifc.mem_resp_valid_i = 0; ifc.mem_resp_id_i = 0; ifc.mem_resp_data_i = 0;
    rstn = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", ifc.req_ready_o, 1'b0);
    check("rst_mem_req_valid", ifc.mem_req_valid_o, 1'b0);
    check("rst_resp_valid", ifc.resp_valid_o, 1'b0);
    check("rst_occupancy", ifc.occupancy_o, 3'd0);
    check("rst_resp_data", ifc.resp_data_o, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();
    check("post_rst_ready", ifc.req_ready_o, 1'b1);

    // single aligned load, response in flight for a few cycles
    do_req(0, 64'h1008, 0, 2'd3, 1, 64'hDEADBEEF_CAFEF00D, 0, t);
    grant(t, 64'h1008, 0, 8'hFF, wd);
    tick(); tick();
    check("t1_no_reissue", ifc.mem_req_valid_o, 1'b0);
    check("t1_occ_inflight", ifc.occupancy_o, 3'd1);
    r0 = n_ret;
    respond(t, 64'hDEADBEEF_CAFEF00D);
    check("t1_no_early_retire", n_ret, r0);
    tick();
    check("t1_retire_latency", n_ret, r0 + 1);
    check("t1_occ_empty", ifc.occupancy_o, 3'd0);

    // four loads, responses out of order, retire in order
    for (int i = 0; i < 4; i++) begin
      dat[i] = {32'hA5A5_0000 + i, 32'h1234_5670 + i};
      do_req(0, 64'h4000 + 64'(8 * i), 0, 2'd3, 1, dat[i], 0, tg[i]);
    end
    check("t2_full_occ", ifc.occupancy_o, 3'd4);
    check("t2_full_not_ready", ifc.req_ready_o, 1'b0);
    for (int i = 0; i < 4; i++) grant(tg[i], 64'h4000 + 64'(8 * i), 0, 8'hFF, wd);
    check("t2_full_after_grant", ifc.req_ready_o, 1'b0);
    order = '{3, 1, 0, 2};
    r0 = n_ret;
    for (int i = 0; i < 4; i++) begin
      respond(tg[order[i]], dat[order[i]]);
      if (i == 1) check("t2_held_for_oldest", n_ret, r0);
    end
    repeat (4) tick();
    check("t2_all_retired", n_ret, r0 + 4);
    check("t2_sb_empty", sbq.size(), 0);
    check("t2_occ_empty", ifc.occupancy_o, 3'd0);

    // byte store into lane 3
    do_req(1, 64'h2003, 64'hFFAB, 2'd0, 1, 0, 0, t);
    r0 = n_ret;
    grant(t, 64'h2003, 1, 8'h08, wd);
    check("t3_wdata_byte3", wd[31:24], 8'hAB);
    tick();
    check("t3_store_retire", n_ret, r0 + 1);

    // halfword load at byte offset 6
    do_req(0, 64'h6006, 0, 2'd1, 1, 64'h1122, 0, t);
    grant(t, 64'h6006, 0, 8'hC0, wd);
    respond(t, 64'h1122334455667788);
    tick();
    check("t3b_sb_empty", sbq.size(), 0);

    // misaligned word load never reaches the dcache
    r0 = n_ret;
    do_req(0, 64'h3002, 0, 2'd2, 1, 0, 1, t);
    neg();
    check("t4_no_issue", ifc.mem_req_valid_o, 1'b0);
    check("t4_xcpt_retire", n_ret, r0 + 1);
    pos();
    tick();
    check("t4_occ_empty", ifc.occupancy_o, 3'd0);

    // kill with one load issued and one still pending
    do_req(0, 64'h5000, 0, 2'd3, 0, 0, 0, ta);
    grant(ta, 64'h5000, 0, 8'hFF, wd);
    do_req(0, 64'h5008, 0, 2'd3, 0, 0, 0, tb_);
    ifc.kill_i = 1'b1; ifc.mem_req_ready_i = 1'b1;
    ifc.req_valid_i = 1'b1; ifc.req_addr_i = 64'h5010; ifc.req_size_i = 2'd3; ifc.req_is_store_i = 0;
    neg();
    check("t5_kill_gates_issue", ifc.mem_req_valid_o, 1'b0);
    check("t5_kill_blocks_req", ifc.req_ready_o, 1'b0);
    pos();
    ifc.kill_i = 1'b0; ifc.req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_pending_not_issued", ifc.mem_req_valid_o, 1'b0);
    end
    check("t5_occ_after_kill", ifc.occupancy_o, 3'd2);
    ifc.mem_req_ready_i = 1'b0;
    respond(ta, 64'h5555_5555_5555_5555);
    repeat (3) tick();
    check("t5_occ_drained", ifc.occupancy_o, 3'd0);
    check("t5_b_tag", tb_, (ta + 1) % DEPTH);

    // full table: retire and new request in the same cycle
    for (int i = 0; i < 4; i++) begin
      dat[i] = {32'h7777_0000 + i, 32'h0BAD_F000 + i};
      do_req(0, 64'h7000 + 64'(8 * i), 0, 2'd3, 1, dat[i], 0, tg[i]);
    end
    for (int i = 0; i < 4; i++) grant(tg[i], 64'h7000 + 64'(8 * i), 0, 8'hFF, wd);
    r0 = n_ret;
    respond(tg[0], dat[0]);
    ifc.req_valid_i = 1'b1; ifc.req_addr_i = 64'h7100; ifc.req_size_i = 2'd3; ifc.req_is_store_i = 0;
    e = '{1'b0, 64'h7100, 64'h0F0F_1234_5678_9ABC, 1'b0, 1'b1};
    sbq.push_back(e);
    neg();
    check("t6_not_ready_on_retire", ifc.req_ready_o, 1'b0);
    check("t6_retire_seen", n_ret, r0 + 1);
    pos();
    neg();
    check("t6_ready_next_cycle", ifc.req_ready_o, 1'b1);
    check("t6_occ_three", ifc.occupancy_o, 3'd3);
    pos();
    ifc.req_valid_i = 1'b0;
    te = n_alloc % DEPTH;
    n_alloc++;
    check("t6_occ_full_again", ifc.occupancy_o, 3'd4);
    respond(tg[2], dat[2]);
    respond(tg[1], dat[1]);
    respond(tg[3], dat[3]);
    grant(te, 64'h7100, 0, 8'hFF, wd);
    respond(te, 64'h0F0F_1234_5678_9ABC);
    repeat (6) tick();
    check("t6_all_retired", n_ret, r0 + 5);
    check("t6_sb_empty", sbq.size(), 0);
    check("t6_occ_empty", ifc.occupancy_o, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
